// File: rtl/ram_access_arbiter_if.sv
// Request/response and RAM-side signals shared between the arbiter and its users.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              r0_valid;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_ready;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_valid;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_ready;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Zero-fills a single-port RAM after reset, then shares it between two
// valid/ready requesters with round-robin arbitration and 1-cycle reads.
module ram_access_arbiter #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_last;
  logic              owner;
  logic              grant0;
  logic              grant1;

  // r0 wins a tie unless it was the last one served
  always_comb begin
    grant0 = (state == IDLE) && bus.r0_valid && (!bus.r1_valid || rr_last);
    grant1 = (state == IDLE) && bus.r1_valid && !grant0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
      rr_last <= 1'b1;
      owner   <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) state <= IDLE;
        end
        IDLE: begin
          if (grant0 || grant1) begin
            rr_last <= grant1;
            if (grant0 && !bus.r0_we) begin
              owner <= 1'b0;
              state <= RESP;
            end else if (grant1 && !bus.r1_we) begin
              owner <= 1'b1;
              state <= RESP;
            end
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced to zero while reset is held, independent of the clock
  always_comb begin
    bus.r0_ready  = 1'b0;
    bus.r0_rvalid = 1'b0;
    bus.r0_rdata  = '0;
    bus.r1_ready  = 1'b0;
    bus.r1_rvalid = 1'b0;
    bus.r1_rdata  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    if (!reset) begin
      unique case (state)
        CLEAR: begin
          bus.busy     = 1'b1;
          bus.mem_we   = 1'b1;
          bus.mem_addr = clr_cnt;
        end
        IDLE: begin
          if (grant0) begin
            bus.r0_ready  = 1'b1;
            bus.mem_we    = bus.r0_we;
            bus.mem_addr  = bus.r0_addr;
            bus.mem_wdata = bus.r0_wdata;
          end else if (grant1) begin
            bus.r1_ready  = 1'b1;
            bus.mem_we    = bus.r1_we;
            bus.mem_addr  = bus.r1_addr;
            bus.mem_wdata = bus.r1_wdata;
          end
        end
        RESP: begin
          if (!owner) begin
            bus.r0_rvalid = 1'b1;
            bus.r0_rdata  = bus.mem_rdata;
          end else begin
            bus.r1_rvalid = 1'b1;
            bus.r1_rdata  = bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 32x4 synchronous RAM.
module tb_ram_access_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  ram_access_arbiter_if #(.ADDR_W(5), .DATA_W(4)) bus ();

  ram_access_arbiter #(.ADDR_W(5), .DATA_W(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [3:0] ram [32];

  always_ff @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic we, input logic [4:0] a, input logic [3:0] d);
    bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic req1(input logic v, input logic we, input logic [4:0] a, input logic [3:0] d);
    bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
    check({tag, "_rdy"},   32'({bus.r0_ready, bus.r1_ready}), 32'd0);
    check({tag, "_rv"},    32'({bus.r0_rvalid, bus.r1_rvalid}), 32'd0);
    check({tag, "_rd"},    32'({bus.r0_rdata, bus.r1_rdata}), 32'd0);
  endtask

  task automatic check_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_we"},    32'(bus.mem_we),    32'd1);
      check({tag, "_addr"},  32'(bus.mem_addr),  32'(i));
      check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
      check({tag, "_busy"},  32'(bus.busy),      32'd1);
      check({tag, "_rdy"},   32'({bus.r0_ready, bus.r1_ready}), 32'd0);
      tick();
    end
    check({tag, "_done_busy"}, 32'(bus.busy),   32'd0);
    check({tag, "_done_we"},   32'(bus.mem_we), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    req0(1'b0, 1'b0, 5'd0, 4'd0);
    req1(1'b0, 1'b0, 5'd0, 4'd0);
    tick();
    tick();
    check_all_zero("reset");

    // 1: zero-fill sweep after release
    reset = 1'b0;
    #1;
    check_sweep("sweep1");

    // 2: r0 write then read back
    req0(1'b1, 1'b1, 5'd1, 4'd2);
    #1;
    check("t2_w_rdy0", 32'(bus.r0_ready), 32'd1);
    check("t2_w_rdy1", 32'(bus.r1_ready), 32'd0);
    check("t2_w_we",   32'(bus.mem_we),   32'd1);
    check("t2_w_addr", 32'(bus.mem_addr), 32'd1);
    check("t2_w_data", 32'(bus.mem_wdata), 32'd2);
    tick();
    req0(1'b1, 1'b0, 5'd1, 4'd0);
    #1;
    check("t2_r_rdy0", 32'(bus.r0_ready), 32'd1);
    check("t2_r_we",   32'(bus.mem_we),   32'd0);
    check("t2_r_addr", 32'(bus.mem_addr), 32'd1);
    tick();
    req0(1'b0, 1'b0, 5'd0, 4'd0);
    #1;
    check("t2_rv",     32'(bus.r0_rvalid), 32'd1);
    check("t2_rdata",  32'(bus.r0_rdata),  32'd2);
    check("t2_rsp_rdy", 32'(bus.r0_ready), 32'd0);
    tick();
    check("t2_rv_end", 32'(bus.r0_rvalid), 32'd0);
    check("t2_rd_end", 32'(bus.r0_rdata),  32'd0);

    // r1 write so that r0 is next in line on a tie
    req1(1'b1, 1'b1, 5'd20, 4'd5);
    #1;
    check("r1w_rdy1", 32'(bus.r1_ready), 32'd1);
    check("r1w_addr", 32'(bus.mem_addr), 32'd20);
    tick();
    req1(1'b0, 1'b0, 5'd0, 4'd0);

    // 3: r0 read vs r1 write to the same address
    req0(1'b1, 1'b0, 5'd10, 4'd0);
    req1(1'b1, 1'b1, 5'd10, 4'd9);
    #1;
    check("t3_rdy0",  32'(bus.r0_ready), 32'd1);
    check("t3_rdy1",  32'(bus.r1_ready), 32'd0);
    check("t3_we",    32'(bus.mem_we),   32'd0);
    check("t3_addr",  32'(bus.mem_addr), 32'd10);
    tick();
    req0(1'b0, 1'b0, 5'd0, 4'd0);
    #1;
    check("t3_rsp_rdy1", 32'(bus.r1_ready),  32'd0);
    check("t3_rsp_rv0",  32'(bus.r0_rvalid), 32'd1);
    check("t3_rsp_rd0",  32'(bus.r0_rdata),  32'd0);
    check("t3_rsp_we",   32'(bus.mem_we),    32'd0);
    tick();
    check("t3_w_rdy1",  32'(bus.r1_ready),  32'd1);
    check("t3_w_we",    32'(bus.mem_we),    32'd1);
    check("t3_w_addr",  32'(bus.mem_addr),  32'd10);
    check("t3_w_data",  32'(bus.mem_wdata), 32'd9);
    tick();
    req1(1'b0, 1'b0, 5'd0, 4'd0);
    req0(1'b1, 1'b0, 5'd10, 4'd0);
    #1;
    check("t3_rb_rdy0", 32'(bus.r0_ready), 32'd1);
    tick();
    req0(1'b0, 1'b0, 5'd0, 4'd0);
    #1;
    check("t3_rb_rv",   32'(bus.r0_rvalid), 32'd1);
    check("t3_rb_data", 32'(bus.r0_rdata),  32'd9);
    tick();

    // r1 read back of addr 20 leaves r0 next in line
    req1(1'b1, 1'b0, 5'd20, 4'd0);
    #1;
    check("r1r_rdy1", 32'(bus.r1_ready), 32'd1);
    tick();
    req1(1'b0, 1'b0, 5'd0, 4'd0);
    #1;
    check("r1r_rv",   32'(bus.r1_rvalid), 32'd1);
    check("r1r_data", 32'(bus.r1_rdata),  32'd5);
    check("r1r_rv0",  32'(bus.r0_rvalid), 32'd0);
    tick();

    // 4: continuous contention alternates grants every cycle
    req0(1'b1, 1'b1, 5'd2, 4'd3);
    req1(1'b1, 1'b1, 5'd3, 4'd4);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t4_rdy0", 32'(bus.r0_ready), 32'((k % 2) == 0));
      check("t4_rdy1", 32'(bus.r1_ready), 32'((k % 2) == 1));
      check("t4_we",   32'(bus.mem_we),   32'd1);
      check("t4_addr", 32'(bus.mem_addr), ((k % 2) == 0) ? 32'd2 : 32'd3);
      tick();
    end
    req0(1'b0, 1'b0, 5'd0, 4'd0);
    req1(1'b0, 1'b0, 5'd0, 4'd0);
    #1;
    check("t4_idle_we",   32'(bus.mem_we),   32'd0);
    check("t4_idle_addr", 32'(bus.mem_addr), 32'd0);

    // 5: reset during the sweep at address 12
    reset = 1'b1;
    #1;
    check_all_zero("t5_rst_a");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("t5_pre_addr", 32'(bus.mem_addr), 32'd12);
    check("t5_pre_busy", 32'(bus.busy),     32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_rst_b");
    tick();
    reset = 1'b0;
    #1;
    check_sweep("sweep5");

    // 6: reset lands in the RESP cycle of an r1 read
    req1(1'b1, 1'b0, 5'd1, 4'd0);
    #1;
    check("t6_rdy1", 32'(bus.r1_ready), 32'd1);
    tick();
    req1(1'b0, 1'b0, 5'd0, 4'd0);
    reset = 1'b1;
    #1;
    check("t6_rv1", 32'(bus.r1_rvalid), 32'd0);
    check("t6_rd1", 32'(bus.r1_rdata),  32'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_post_rv1",   32'(bus.r1_rvalid), 32'd0);
      check("t6_post_rd1",   32'(bus.r1_rdata),  32'd0);
      check("t6_post_addr",  32'(bus.mem_addr),  32'(i));
      check("t6_post_busy",  32'(bus.busy),      32'd1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
